// File: rtl/ser_tx_shifter_pkg.sv
// ser_tx_shifter_pkg: shared FSM state type and default idle line level
package ser_tx_pkg;
    typedef enum logic {IDLE, SHIFT} state_t;
    localparam logic IDLE_LEVEL_DEFAULT = 1'b0;
endpackage

// File: rtl/ser_tx_shifter_if.sv
// ser_tx_shifter_if: load handshake, abort and serial output bundle
interface ser_tx_shifter_if #(parameter int WIDTH = 8);
    logic             load_valid;
    logic [WIDTH-1:0] load_data;
    logic             load_ready;
    logic             abort;
    logic             ser_out;
    logic             ser_frame;
    logic             busy;
    logic             done;
    modport master (output load_valid, load_data, abort,
                    input  load_ready, ser_out, ser_frame, busy, done);
    modport slave  (input  load_valid, load_data, abort,
                    output load_ready, ser_out, ser_frame, busy, done);
endinterface

// File: rtl/ser_tx_shifter_bit_tick_gen.sv
// bit_tick_gen: flags the last clock of each DIV-clock bit period
module bit_tick_gen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    logic [CW-1:0] cnt;
    assign tick = en && (cnt == CW'(DIV - 1));
    // count 0..DIV-1 while enabled, restart on clear, idle or period end
    always_ff @(posedge clk or posedge reset)
        if (reset)
            cnt <= '0;
        else
            cnt <= (clr || !en || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/ser_tx_shifter.sv
// ser_tx_shifter: parallel-to-serial transmitter with frame strobe and abort
module ser_tx_shifter
    import ser_tx_pkg::*;
#(
    parameter int   WIDTH      = 8,
    parameter int   DIV        = 4,
    parameter bit   MSB_FIRST  = 1'b1,
    parameter logic IDLE_LEVEL = IDLE_LEVEL_DEFAULT
) (
    input logic             clk,
    input logic             reset,
    ser_tx_shifter_if.slave bus
);
    localparam int BW = $clog2(WIDTH + 1);
    state_t           state;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] sreg_next;
    logic [BW-1:0]    bit_cnt;
    logic             ser_out_q;
    logic             frame_q;
    logic             done_q;
    logic             tick;
    logic             accept;
    logic             kill;
    logic             first_bit;
    logic             next_bit;
    logic             last_bit;
    assign accept    = (state == IDLE) && bus.load_valid;
    assign kill      = (state == SHIFT) && bus.abort;
    assign first_bit = MSB_FIRST ? bus.load_data[WIDTH-1] : bus.load_data[0];
    assign sreg_next = MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};
    assign next_bit  = MSB_FIRST ? sreg_next[WIDTH-1] : sreg_next[0];
    assign last_bit  = bit_cnt == BW'(WIDTH - 1);
    bit_tick_gen #(.DIV(DIV)) u_tick (
        .clk  (clk),
        .reset(reset),
        .en   (state == SHIFT),
        .clr  (kill),
        .tick (tick)
    );
    // frame FSM: load on handshake, shift on bit tick, abort beats completion
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state     <= IDLE;
            sreg      <= '0;
            bit_cnt   <= '0;
            ser_out_q <= IDLE_LEVEL;
            frame_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                state     <= SHIFT;
                sreg      <= bus.load_data;
                bit_cnt   <= '0;
                ser_out_q <= first_bit;
                frame_q   <= 1'b1;
            end else if (kill || (state == SHIFT && tick && last_bit)) begin
                state     <= IDLE;
                bit_cnt   <= '0;
                ser_out_q <= IDLE_LEVEL;
                frame_q   <= 1'b0;
                done_q    <= !kill;
            end else if (state == SHIFT && tick) begin
                sreg      <= sreg_next;
                bit_cnt   <= bit_cnt + 1'b1;
                ser_out_q <= next_bit;
            end
        end
    assign bus.load_ready = state == IDLE;
    assign bus.busy       = state == SHIFT;
    assign bus.ser_out    = ser_out_q;
    assign bus.ser_frame  = frame_q;
    assign bus.done       = done_q;
endmodule
